iddr_rx_gearbox: RTL and testbench

//  Consumes the Q0/Q1 bit pairs from an IDDRX1F input DDR cell, deserialises them into

---
 rtl/iddr_rx_gearbox.sv | 185 ++++++++++++++++++
 tb/tb_iddr_rx_gearbox.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/iddr_rx_gearbox.sv
// iddr_rx_gearbox: turns IDDRX1F Q0/Q1 bit pairs into WIDTH-bit words and
// aligns the word boundary to a training pattern by single-bit slips.
module iddr_rx_gearbox #(
  parameter int unsigned      WIDTH         = 8,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(8'hB4),
  parameter int unsigned      LOCK_COUNT    = 4,
  parameter int unsigned      SLIP_WAIT     = 2
) (
  input  logic                     SCLK,
  input  logic                     RST,
  input  logic                     Q0,
  input  logic                     Q1,
  input  logic                     ALIGN_EN,
  output logic [WIDTH-1:0]         DATA,
  output logic                     VALID,
  output logic                     LOCKED,
  output logic [$clog2(WIDTH)-1:0] SLIP_CNT,
  output logic                     ALIGN_ERR
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LOCK   = 2'd3
  } state_t;

  // Gearbox state: r_acc holds the bits of the current partial word (LSB newest),
  // r_fill counts them, r_skip drops the next Q0 to realise a slip.
  logic [WIDTH-2:0] r_acc;
  logic [CNT_W-1:0] r_fill;
  logic             r_skip;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  state_t           r_state;
  logic [3:0]       r_match_cnt;
  logic [3:0]       r_wait_cnt;
  logic [CNT_W-1:0] r_rot_cnt;
  logic [CNT_W-1:0] r_slip_cnt;
  logic             r_locked;
  logic             r_align_err;

  logic [SUM_W-1:0] w_sum;
  logic             w_done;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH-2:0] w_acc_next;
  logic [CNT_W-1:0] w_fill_base;
  logic [CNT_W-1:0] w_fill_next;
  logic             w_skip_next;
  logic             w_slip;
  logic             w_match_last;
  logic             w_wait_last;
  logic             w_rot_last;
  logic [CNT_W-1:0] w_slip_cnt_inc;

  assign w_slip         = w_done && (r_state == ST_SEARCH) && ALIGN_EN && (w_word != TRAIN_PATTERN);
  assign w_match_last   = (5'(r_match_cnt) + 5'd1) == 5'(LOCK_COUNT);
  assign w_wait_last    = (5'(r_wait_cnt) + 5'd1) == 5'(SLIP_WAIT);
  assign w_rot_last     = r_rot_cnt == CNT_W'(WIDTH - 1);
  assign w_slip_cnt_inc = (r_slip_cnt == CNT_W'(WIDTH - 1)) ? '0 : r_slip_cnt + CNT_W'(1);

  // Word assembly: detect word completion, pick the word bits, and apply a slip
  // by discarding the bit right after the completed word.
  always_comb begin
    w_sum       = SUM_W'(r_fill) + (r_skip ? SUM_W'(1) : SUM_W'(2));
    w_done      = 1'b0;
    w_word      = {r_acc, Q0};
    w_acc_next  = r_skip ? {r_acc[WIDTH-3:0], Q1} : {r_acc[WIDTH-4:0], Q0, Q1};
    w_fill_base = CNT_W'(w_sum);
    w_fill_next = w_fill_base;
    w_skip_next = 1'b0;
    if (!r_skip) begin
      if (w_sum == SUM_W'(WIDTH)) begin
        w_done      = 1'b1;
        w_word      = {r_acc[WIDTH-3:0], Q0, Q1};
        w_fill_base = '0;
      end else if (w_sum == SUM_W'(WIDTH + 1)) begin
        // odd boundary: Q0 closes this word, Q1 carries into the next
        w_done      = 1'b1;
        w_word      = {r_acc, Q0};
        w_fill_base = CNT_W'(1);
      end
    end
    w_fill_next = w_fill_base;
    if (w_slip) begin
      // drop the carried Q1 if there is one, otherwise the next Q0
      w_fill_next = '0;
      w_skip_next = (w_fill_base == '0);
    end
  end

  // Datapath registers and the registered word/strobe outputs
  always_ff @(posedge SCLK or posedge RST) begin
    if (RST) begin
      r_acc   <= '0;
      r_fill  <= '0;
      r_skip  <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_acc   <= w_acc_next;
      r_fill  <= w_fill_next;
      r_skip  <= w_skip_next;
      r_valid <= w_done;
      if (w_done) begin
        r_data <= w_word;
      end
    end
  end

  // Alignment FSM: acts on word completions, except the ALIGN_EN check every cycle
  always_ff @(posedge SCLK or posedge RST) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_match_cnt <= '0;
      r_wait_cnt  <= '0;
      r_rot_cnt   <= '0;
      r_slip_cnt  <= '0;
      r_locked    <= 1'b0;
      r_align_err <= 1'b0;
    end else if (!ALIGN_EN) begin
      r_state  <= ST_IDLE;
      r_locked <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state     <= ST_SEARCH;
          r_match_cnt <= '0;
          r_wait_cnt  <= '0;
          r_rot_cnt   <= '0;
          r_align_err <= 1'b0;
          r_locked    <= 1'b0;
        end
        ST_SEARCH: begin
          if (w_done) begin
            if (!w_slip) begin
              if (w_match_last) begin
                r_state  <= ST_LOCK;
                r_locked <= 1'b1;
              end
              r_match_cnt <= r_match_cnt + 4'd1;
            end else begin
              r_match_cnt <= '0;
              r_wait_cnt  <= '0;
              r_slip_cnt  <= w_slip_cnt_inc;
              if (w_rot_last) begin
                r_rot_cnt   <= '0;
                r_align_err <= 1'b1;
              end else begin
                r_rot_cnt <= r_rot_cnt + CNT_W'(1);
              end
              r_state <= (SLIP_WAIT == 0) ? ST_SEARCH : ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (w_done) begin
            if (w_wait_last) begin
              r_state <= ST_SEARCH;
            end else begin
              r_wait_cnt <= r_wait_cnt + 4'd1;
            end
          end
        end
        ST_LOCK: begin
          r_locked <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign DATA      = r_data;
  assign VALID     = r_valid;
  assign LOCKED    = r_locked;
  assign SLIP_CNT  = r_slip_cnt;
  assign ALIGN_ERR = r_align_err;

endmodule

// File: tb/tb_iddr_rx_gearbox.sv
// Directed bench for iddr_rx_gearbox (WIDTH=8, pattern 8'hB4, lock 4, wait 2).
module tb_iddr_rx_gearbox;

  localparam int unsigned SBITS = 1024;

  logic       SCLK = 1'b0;
  logic       RST = 1'b1;
  logic       Q0 = 1'b0;
  logic       Q1 = 1'b0;
  logic       ALIGN_EN = 1'b0;
  logic [7:0] DATA;
  logic       VALID;
  logic       LOCKED;
  logic [2:0] SLIP_CNT;
  logic       ALIGN_ERR;

  int   n_vec = 0;
  int   n_err = 0;
  int   p = 0;
  int   rise = 0;
  logic s_bits [0:SBITS-1];

  iddr_rx_gearbox #(
    .WIDTH(8), .TRAIN_PATTERN(8'hB4), .LOCK_COUNT(4), .SLIP_WAIT(2)
  ) dut (
    .SCLK(SCLK), .RST(RST), .Q0(Q0), .Q1(Q1), .ALIGN_EN(ALIGN_EN),
    .DATA(DATA), .VALID(VALID), .LOCKED(LOCKED), .SLIP_CNT(SLIP_CNT),
    .ALIGN_ERR(ALIGN_ERR)
  );

  always #5 SCLK = ~SCLK;

  // pair index and rise count since reset release
  always @(posedge SCLK) begin
    if (RST) begin
      p = 0;
      rise = 0;
    end else begin
      p = p + 1;
      rise = rise + 1;
    end
  end

  function automatic logic get_bit(input int i);
    return (i < SBITS) ? s_bits[i] : 1'b0;
  endfunction

  // present pair p ahead of the next rise
  always @(negedge SCLK) begin
    Q0 = get_bit(2 * p);
    Q1 = get_bit(2 * p + 1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_stream();
    for (int i = 0; i < int'(SBITS); i++) s_bits[i] = 1'b0;
  endtask

  task automatic load_word(input int start, input logic [7:0] w);
    for (int i = 0; i < 8; i++) s_bits[start + i] = w[7 - i];
  endtask

  task automatic apply_reset();
    @(negedge SCLK);
    RST = 1'b1;
    repeat (2) @(negedge SCLK);
    RST = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int r);
    r = -1;
    for (int i = 0; i < limit; i++) begin
      @(posedge SCLK);
      #1;
      if (VALID) begin
        r = rise;
        break;
      end
    end
  endtask

  initial begin
    int         r;
    int         slips;
    logic [2:0] prev;
    logic [7:0] pat;
    pat = 8'hB4;

    // 1: reset mid-word, then restart from stream bit 0
    clear_stream();
    load_word(0, 8'hA5);
    ALIGN_EN = 1'b0;
    apply_reset();
    wait_valid(8, r);
    check("t1_pre_rise", 32'(r), 32'd4);
    check("t1_pre_data", 32'(DATA), 32'hA5);
    @(posedge SCLK);
    @(posedge SCLK);
    #2;
    RST = 1'b1;
    #1;
    check("t1_rst_data", 32'(DATA), 32'h0);
    check("t1_rst_valid", 32'(VALID), 32'h0);
    check("t1_rst_locked", 32'(LOCKED), 32'h0);
    check("t1_rst_slip", 32'(SLIP_CNT), 32'h0);
    check("t1_rst_err", 32'(ALIGN_ERR), 32'h0);
    repeat (2) @(negedge SCLK);
    RST = 1'b0;
    wait_valid(8, r);
    check("t1_first_rise", 32'(r), 32'd4);
    check("t1_first_data", 32'(DATA), 32'hA5);

    // 2: pass-through, two words from bit 0
    clear_stream();
    load_word(0, 8'hA5);
    load_word(8, 8'h3C);
    apply_reset();
    wait_valid(8, r);
    check("t2_rise0", 32'(r), 32'd4);
    check("t2_data0", 32'(DATA), 32'hA5);
    check("t2_slip0", 32'(SLIP_CNT), 32'd0);
    wait_valid(8, r);
    check("t2_rise1", 32'(r), 32'd8);
    check("t2_data1", 32'(DATA), 32'h3C);
    check("t2_slip1", 32'(SLIP_CNT), 32'd0);
    check("t2_locked", 32'(LOCKED), 32'd0);

    // 3: pattern delayed by 3 bits; slips at words 0,3,6, lock on word 12 (rise 54)
    clear_stream();
    for (int i = 0; i < 107; i++) s_bits[i] = pat[7 - ((i + 5) % 8)];
    load_word(107, 8'h12);
    load_word(115, 8'h34);
    ALIGN_EN = 1'b1;
    apply_reset();
    r = -1;
    for (int i = 0; i < 120; i++) begin
      @(posedge SCLK);
      #1;
      if (LOCKED) begin
        r = rise;
        break;
      end
    end
    check("t3_lock_rise", 32'(r), 32'd54);
    check("t3_slip", 32'(SLIP_CNT), 32'd3);
    check("t3_data", 32'(DATA), 32'hB4);
    check("t3_valid", 32'(VALID), 32'd1);
    check("t3_err", 32'(ALIGN_ERR), 32'd0);

    // 4: data on the odd locked boundary
    wait_valid(8, r);
    check("t4_rise0", 32'(r), 32'd58);
    check("t4_data0", 32'(DATA), 32'h12);
    wait_valid(8, r);
    check("t4_rise1", 32'(r), 32'd62);
    check("t4_data1", 32'(DATA), 32'h34);
    check("t4_locked", 32'(LOCKED), 32'd1);
    check("t4_slip", 32'(SLIP_CNT), 32'd3);

    // 6a: drop ALIGN_EN while locked
    @(negedge SCLK);
    ALIGN_EN = 1'b0;
    @(posedge SCLK);
    #1;
    check("t6_unlock", 32'(LOCKED), 32'd0);
    check("t6_slip_kept", 32'(SLIP_CNT), 32'd3);
    wait_valid(8, r);
    check("t6_cadence", 32'(r), 32'd66);

    // 5: constant zeros, full rotation without lock
    clear_stream();
    ALIGN_EN = 1'b1;
    apply_reset();
    slips = 0;
    prev = 3'd0;
    for (int i = 0; i < 300; i++) begin
      @(posedge SCLK);
      #1;
      if (SLIP_CNT != prev) begin
        slips++;
        prev = SLIP_CNT;
      end
      if (ALIGN_ERR) break;
    end
    check("t5_slips", 32'(slips), 32'd8);
    check("t5_err", 32'(ALIGN_ERR), 32'd1);
    check("t5_slip", 32'(SLIP_CNT), 32'd0);
    check("t5_locked", 32'(LOCKED), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(posedge SCLK);
      #1;
      if (SLIP_CNT == 3'd1) break;
    end
    check("t5_keeps_slipping", 32'(SLIP_CNT), 32'd1);

    // 6b: ALIGN_ERR kept through IDLE, cleared on re-enable
    @(negedge SCLK);
    ALIGN_EN = 1'b0;
    @(posedge SCLK);
    #1;
    check("t6_err_kept", 32'(ALIGN_ERR), 32'd1);
    check("t6_slip_kept2", 32'(SLIP_CNT), 32'd1);
    @(negedge SCLK);
    ALIGN_EN = 1'b1;
    @(posedge SCLK);
    #1;
    check("t6_err_clear", 32'(ALIGN_ERR), 32'd0);
    check("t6_locked_off", 32'(LOCKED), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
